mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the fetch stage and the memory stage of the pipelined core. It accepts a word fetch request and a load/store request (lw, lbu, sw, sb), serialises them onto one multi-cycle memory port, and drives per-requester stall signals that freeze the pipeline until each access completes. It sits between the F/M pipeline stages and the memory model, replacing the separate instruction and data memories.

## Interface
- ADDRESS_WIDTH, 32, width of all addresses
- DATA_WIDTH, 32, memory word width (fixed at 32; byte lanes assume 4 bytes)
- MEM_LATENCY, 2, cycles from MemEn pulse until MemRdata is valid (legal range ≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- IReq  in  1  fetch request, held until IStall low
- IAddr  in  ADDRESS_WIDTH  fetch address (word access)
- IRdata  out  32  fetched instruction, valid when IReq && !IStall
- IStall  out  1  fetch must hold
- DReq  in  1  load/store request, held until DStall low
- DWe  in  1  1 = store (MemWrite), 0 = load
- DByte  in  1  1 = byte access (sb/lbu), 0 = word (sw/lw)
- DAddr  in  ADDRESS_WIDTH  data address
- DWdata  in  32  store data (byte in [7:0] for sb)
- DRdata  out  32  load data, valid when DReq && !DStall && !DWe
- DStall  out  1  memory stage must hold
- MemEn  out  1  one-cycle access strobe
- MemWe  out  1  write enable, qualified by MemEn
- MemAddr  out  ADDRESS_WIDTH  word-aligned address {addr[31:2],2'b00}
- MemWdata  out  32  write data
- MemBe  out  4  byte enables
- MemRdata  in  32  read word, valid MEM_LATENCY cycles after MemEn

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request, latch owner, address, DWe, DByte, DWdata; go ISSUE. Else stay.
- Grant: DReq wins, except when last grant was D and IReq is asserted, then I wins. Last-grant register updates on each grant.
- ISSUE: MemEn=1 for this cycle only, MemWe = latched DWe (0 for fetch). Store → RESP; load/fetch → WAIT, counter loaded MEM_LATENCY-1.
- WAIT: lasts exactly MEM_LATENCY cycles; counter decrements; in the cycle counter is 0, capture MemRdata into response register, go RESP.
- RESP: one cycle; owner's stall low; next state IDLE.
- IStall = IReq && !(RESP && owner==I); DStall = DReq && !(RESP && owner==D). Stalls are combinational from state and request.
- Word access: MemBe=4'hF, DAddr[1:0] ignored. sb: MemBe = 1<<DAddr[1:0], MemWdata = DWdata[7:0] replicated ×4. lbu: DRdata = zero-extended byte DAddr[1:0] of captured word. lw/fetch: full word.
- Request dropped mid-transaction (flush): transaction still completes, including any write; response discarded; stall follows request, so it goes low immediately.
- Reset: state IDLE, counter 0, last-grant = I (D wins first contention), IRdata/DRdata/response register 0, MemEn 0, MemWe 0, MemAddr 0, MemWdata 0, MemBe 0. Reset mid-WAIT/ISSUE aborts; no strobe is re-issued.

## Timing
- Request seen in IDLE at cycle t: MemEn at t+1. Load/fetch response at RESP = t+2+MEM_LATENCY; stall high t..t+1+MEM_LATENCY. Store RESP at t+2; stall high t..t+1.
- Back-to-back: new grant earliest in IDLE at RESP+1. Pending loser is served next.
- MemAddr/MemWdata/MemBe/MemWe come from registers and are stable from ISSUE through RESP.
- Simultaneous IReq and DReq in IDLE: exactly one is granted; the other's stall stays high throughout.

## Test plan
- Reset, then IReq=1 IAddr=0x10 with MEM_LATENCY=2, memory word 0x00500093 -> MemEn at t+1 with MemAddr=0x10; IStall high 4 cycles; IRdata=0x00500093 at t+4.
- DReq sw DAddr=0x20 DWdata=0xDEADBEEF -> MemEn/MemWe at t+1, MemBe=4'hF; DStall low at t+2.
- sb DAddr=0x23 DWdata=0x000000AB, then lbu DAddr=0x23 -> MemBe=4'b1000, MemWdata=0xABABABAB; lbu DRdata=0x000000AB.
- IReq and DReq both held from reset -> D served first, then I, then D again (alternation); no requester starves.
- DReq lw, deassert DReq during WAIT -> DStall low immediately; FSM still reaches RESP then IDLE; next IReq served normally.
- Assert rst during WAIT -> next cycle IDLE, MemEn=0, all outputs at reset values; pending request re-served from ISSUE after rst falls.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, load/store port and the single memory port.
// slave = arbiter view; master = core plus memory model view.
interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     IReq;
  logic [ADDRESS_WIDTH-1:0] IAddr;
  logic [DATA_WIDTH-1:0]    IRdata;
  logic                     IStall;

  logic                     DReq;
  logic                     DWe;
  logic                     DByte;
  logic [ADDRESS_WIDTH-1:0] DAddr;
  logic [DATA_WIDTH-1:0]    DWdata;
  logic [DATA_WIDTH-1:0]    DRdata;
  logic                     DStall;

  logic                     MemEn;
  logic                     MemWe;
  logic [ADDRESS_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0]    MemWdata;
  logic [3:0]               MemBe;
  logic [DATA_WIDTH-1:0]    MemRdata;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DByte, DAddr, DWdata, MemRdata,
    output IRdata, IStall, DRdata, DStall, MemEn, MemWe, MemAddr, MemWdata, MemBe
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DByte, DAddr, DWdata, MemRdata,
    input  IRdata, IStall, DRdata, DStall, MemEn, MemWe, MemAddr, MemWdata, MemBe
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one multi-cycle memory port.
// Load/fetch answers MEM_LATENCY+2 cycles after the request, stores after 2; requesters stall until then.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state, state_nxt;
  logic                     owner_d;
  logic                     last_d;
  logic                     we_q;
  logic                     byte_q;
  logic [1:0]               off_q;
  logic [CW-1:0]            cnt;
  logic [DATA_WIDTH-1:0]    resp_q;
  logic                     grant;
  logic                     grant_d;
  logic [ADDRESS_WIDTH-1:0] req_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // D has priority unless it took the previous slot and fetch is waiting.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        grant   = bus.IReq || bus.DReq;
        grant_d = bus.DReq && !(last_d && bus.IReq);
        if (grant) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_addr = grant_d ? bus.DAddr : bus.IAddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d      <= 1'b0;
      last_d       <= 1'b0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      off_q        <= 2'b00;
      cnt          <= '0;
      resp_q       <= '0;
      bus.MemEn    <= 1'b0;
      bus.MemWe    <= 1'b0;
      bus.MemAddr  <= '0;
      bus.MemWdata <= '0;
      bus.MemBe    <= 4'h0;
    end else begin
      bus.MemEn <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner_d     <= grant_d;
            last_d      <= grant_d;
            we_q        <= grant_d && bus.DWe;
            byte_q      <= grant_d && bus.DByte;
            off_q       <= req_addr[1:0];
            bus.MemEn   <= 1'b1;
            bus.MemWe   <= grant_d && bus.DWe;
            bus.MemAddr <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
            if (grant_d && bus.DByte) begin
              bus.MemWdata <= {4{bus.DWdata[7:0]}};
              bus.MemBe    <= bus.DWe ? (4'b0001 << req_addr[1:0]) : 4'hF;
            end else begin
              bus.MemWdata <= grant_d ? bus.DWdata : '0;
              bus.MemBe    <= 4'hF;
            end
          end
        end
        ISSUE: cnt <= CW'(MEM_LATENCY - 1);
        WAIT: begin
          if (cnt == '0) resp_q <= bus.MemRdata;
          else           cnt    <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.IRdata = resp_q;
  assign bus.DRdata = byte_q ? {{(DATA_WIDTH-8){1'b0}}, resp_q[{off_q, 3'b000} +: 8]} : resp_q;

  // Stall tracks the live request, so a flushed requester is released at once.
  assign bus.IStall = bus.IReq && !(state == RESP && !owner_d);
  assign bus.DStall = bus.DReq && !(state == RESP &&  owner_d);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a word-array memory model and directed corner cases.
module tb_mem_arbiter;
  localparam int L  = 2;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) bus ();
  mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       we;
    logic [7:0] idx;
    logic [31:0] exp;
  } dexp_t;

  typedef struct {
    int          hi;
    int          en_k;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] rdata;
  } res_t;

  logic [31:0] phys [256];
  logic [31:0] refm [256];
  logic [31:0] dline [L];
  logic [31:0] iq [$];
  dexp_t       dq [$];
  byte         served [$];
  int          total = 0;
  int          bad   = 0;
  logic        prev_en = 1'b0;

  // Memory: read data emerges L cycles after the strobe, random filler otherwise.
  assign bus.MemRdata = dline[L-1];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) dline[i] <= dline[i-1];
    if (bus.MemEn && !bus.MemWe) dline[0] <= phys[bus.MemAddr[9:2]];
    else                         dline[0] <= $urandom;
    if (bus.MemEn && bus.MemWe)
      for (int b = 0; b < 4; b++)
        if (bus.MemBe[b]) phys[bus.MemAddr[9:2]][8*b +: 8] <= bus.MemWdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void expect_i(input logic [31:0] a);
    iq.push_back(refm[a[9:2]]);
  endfunction

  function automatic void expect_d(input logic we, input logic byt, input logic [31:0] a, input logic [31:0] wd);
    dexp_t       e;
    logic [31:0] w;
    int          sh;
    w     = refm[a[9:2]];
    sh    = 8 * int'(a[1:0]);
    e.we  = we;
    e.idx = a[9:2];
    if (we) begin
      if (byt) w = (w & ~(32'hFF << sh)) | ({24'b0, wd[7:0]} << sh);
      else     w = wd;
      refm[a[9:2]] = w;
      e.exp = w;
    end else begin
      e.exp = byt ? ((w >> sh) & 32'hFF) : w;
    end
    dq.push_back(e);
  endfunction

  task automatic do_i(input logic [31:0] a, output res_t r);
    bit done;
    r.hi = 0; r.en_k = -1; r.addr = '0; r.wdata = '0; r.be = '0; r.we = 1'b0; r.rdata = '0;
    done = 1'b0;
    @(posedge clk); #1;
    bus.IReq  = 1'b1;
    bus.IAddr = a;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.MemEn && r.en_k < 0) begin
        r.en_k = k; r.addr = bus.MemAddr; r.wdata = bus.MemWdata; r.be = bus.MemBe; r.we = bus.MemWe;
      end
      if (!bus.IStall) begin
        r.rdata = bus.IRdata;
        done = 1'b1;
      end else begin
        r.hi++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL i_timeout: IStall still %b after 200 cycles, want 0", bus.IStall);
    end
  endtask

  task automatic do_d(input logic we, input logic byt, input logic [31:0] a, input logic [31:0] wd, output res_t r);
    bit done;
    r.hi = 0; r.en_k = -1; r.addr = '0; r.wdata = '0; r.be = '0; r.we = 1'b0; r.rdata = '0;
    done = 1'b0;
    @(posedge clk); #1;
    bus.DReq   = 1'b1;
    bus.DWe    = we;
    bus.DByte  = byt;
    bus.DAddr  = a;
    bus.DWdata = wd;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.MemEn && r.en_k < 0) begin
        r.en_k = k; r.addr = bus.MemAddr; r.wdata = bus.MemWdata; r.be = bus.MemBe; r.we = bus.MemWe;
      end
      if (!bus.DStall) begin
        r.rdata = bus.DRdata;
        done = 1'b1;
      end else begin
        r.hi++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL d_timeout: DStall still %b after 200 cycles, want 0", bus.DStall);
    end
  endtask

  // Scoreboard monitor: every completed access pops one expectation.
  always @(negedge clk) begin
    dexp_t e;
    if (!rst) begin
      if (bus.MemEn) chk("memen_one_cycle", 32'(prev_en), 32'd0);
      if (bus.IReq && !bus.IStall) begin
        served.push_back("I");
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL i_unexpected: got response %h, want none", bus.IRdata);
        end else begin
          chk("irdata", bus.IRdata, iq.pop_front());
        end
      end
      if (bus.DReq && !bus.DStall) begin
        served.push_back("D");
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL d_unexpected: got response %h, want none", bus.DRdata);
        end else begin
          e = dq.pop_front();
          if (e.we) chk("store_word", phys[e.idx], e.exp);
          else      chk("drdata", bus.DRdata, e.exp);
        end
      end
    end
    prev_en <= bus.MemEn;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        r;
    logic [31:0] v;
    int          hi;
    int          ens;
    bit          done;
    byte         e;

    rst = 1'b1;
    bus.IReq = 1'b1; bus.IAddr = '0;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DByte = 1'b0; bus.DAddr = '0; bus.DWdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = (i == 4) ? 32'h0050_0093 : $urandom;
      phys[i] <= v;
      refm[i] = v;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_istall", 32'(bus.IStall), 32'd1);
    chk("rst_dstall", 32'(bus.DStall), 32'd1);
    chk("rst_memen", 32'(bus.MemEn), 32'd0);
    chk("rst_memwe", 32'(bus.MemWe), 32'd0);
    chk("rst_memaddr", bus.MemAddr, 32'd0);
    chk("rst_memwdata", bus.MemWdata, 32'd0);
    chk("rst_membe", 32'(bus.MemBe), 32'd0);
    chk("rst_irdata", bus.IRdata, 32'd0);
    chk("rst_drdata", bus.DRdata, 32'd0);
    bus.IReq = 1'b0; bus.DReq = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Plain fetch
    expect_i(32'h10);
    do_i(32'h10, r);
    chk("fetch_stall_len", r.hi, L + 2);
    chk("fetch_memen_cycle", r.en_k, 1);
    chk("fetch_memaddr", r.addr, 32'h10);
    chk("fetch_memwe", 32'(r.we), 32'd0);
    chk("fetch_irdata", r.rdata, 32'h0050_0093);
    @(posedge clk); #1 bus.IReq = 1'b0;

    // Word store, byte store, byte load
    expect_d(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF);
    do_d(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, r);
    chk("sw_stall_len", r.hi, 2);
    chk("sw_memen_cycle", r.en_k, 1);
    chk("sw_memwe", 32'(r.we), 32'd1);
    chk("sw_membe", 32'(r.be), 32'hF);
    chk("sw_memwdata", r.wdata, 32'hDEAD_BEEF);
    expect_d(1'b1, 1'b1, 32'h23, 32'h0000_00AB);
    do_d(1'b1, 1'b1, 32'h23, 32'h0000_00AB, r);
    chk("sb_membe", 32'(r.be), 32'h8);
    chk("sb_memwdata", r.wdata, 32'hABAB_ABAB);
    chk("sb_memaddr", r.addr, 32'h20);
    expect_d(1'b0, 1'b1, 32'h23, 32'h0);
    do_d(1'b0, 1'b1, 32'h23, 32'h0, r);
    chk("lbu_stall_len", r.hi, L + 2);
    chk("lbu_drdata", r.rdata, 32'h0000_00AB);
    @(posedge clk); #1 bus.DReq = 1'b0;

    // Both requesters held from reset must alternate, D first
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    served.delete();
    fork
      begin
        res_t rd;
        logic [31:0] ad;
        for (int n = 0; n < 3; n++) begin
          ad = 32'h100 + 32'(n * 4);
          expect_d(1'b0, 1'b0, ad, 32'h0);
          do_d(1'b0, 1'b0, ad, 32'h0, rd);
        end
        @(posedge clk); #1 bus.DReq = 1'b0;
      end
      begin
        res_t ri;
        logic [31:0] ai;
        for (int n = 0; n < 3; n++) begin
          ai = 32'h40 + 32'(n * 4);
          expect_i(ai);
          do_i(ai, ri);
        end
        @(posedge clk); #1 bus.IReq = 1'b0;
      end
    join
    chk("alt_count", served.size(), 6);
    for (int i = 0; i < 6 && i < served.size(); i++) begin
      e = (i % 2 == 0) ? "D" : "I";
      chk("alt_order", 32'(served[i]), 32'(e));
    end

    // Load flushed during WAIT; the port must drain and serve the next fetch normally
    @(posedge clk); #1;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DByte = 1'b0; bus.DAddr = 32'h104;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 bus.DReq = 1'b0;
    @(negedge clk);
    chk("flush_dstall", 32'(bus.DStall), 32'd0);
    repeat (3) @(posedge clk);
    expect_i(32'h44);
    do_i(32'h44, r);
    chk("after_flush_stall_len", r.hi, L + 2);
    chk("after_flush_memen_cycle", r.en_k, 1);
    @(posedge clk); #1 bus.IReq = 1'b0;

    // Reset in WAIT aborts, then the held load is re-issued exactly once
    expect_d(1'b0, 1'b0, 32'h108, 32'h0);
    @(posedge clk); #1;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DByte = 1'b0; bus.DAddr = 32'h108;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstwait_memen", 32'(bus.MemEn), 32'd0);
    chk("rstwait_memwe", 32'(bus.MemWe), 32'd0);
    chk("rstwait_memaddr", bus.MemAddr, 32'd0);
    chk("rstwait_membe", 32'(bus.MemBe), 32'd0);
    chk("rstwait_memwdata", bus.MemWdata, 32'd0);
    chk("rstwait_drdata", bus.DRdata, 32'd0);
    chk("rstwait_dstall", 32'(bus.DStall), 32'd1);
    hi = 1; ens = 0; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.MemEn) ens++;
      if (!bus.DStall) done = 1'b1;
      else             hi++;
    end
    chk("rstwait_stall_len", hi, L + 2);
    chk("rstwait_strobes", ens, 1);
    @(posedge clk); #1 bus.DReq = 1'b0;

    // Randomised concurrent traffic
    fork
      begin
        res_t ri;
        logic [31:0] ai;
        int gap;
        for (int n = 0; n < 40; n++) begin
          ai = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
          expect_i(ai);
          do_i(ai, ri);
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            @(posedge clk); #1 bus.IReq = 1'b0;
            repeat (gap - 1) @(posedge clk);
          end
        end
        @(posedge clk); #1 bus.IReq = 1'b0;
      end
      begin
        res_t rd;
        logic [31:0] ad, wd;
        logic we, byt;
        int gap;
        for (int n = 0; n < 40; n++) begin
          we  = 1'($urandom_range(0, 1));
          byt = 1'($urandom_range(0, 1));
          ad  = 32'h100 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
          wd  = $urandom;
          if (!we && $urandom_range(0, 5) == 0) begin
            @(posedge clk); #1;
            bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DByte = byt; bus.DAddr = ad;
            repeat ($urandom_range(1, L + 1)) @(negedge clk);
            @(posedge clk); #1 bus.DReq = 1'b0;
            repeat (L + 4) @(posedge clk);
          end else begin
            expect_d(we, byt, ad, wd);
            do_d(we, byt, ad, wd, rd);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
              @(posedge clk); #1 bus.DReq = 1'b0;
              repeat (gap - 1) @(posedge clk);
            end
          end
        end
        @(posedge clk); #1 bus.DReq = 1'b0;
      end
    join

    repeat (L + 4) @(posedge clk);
    chk("i_queue_drained", iq.size(), 0);
    chk("d_queue_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
